// File: rtl/zap_add64_pkg.sv
// Shared encodings for the 64-bit add/subtract sequencer: op codes,
// FSM state constants and NZCV flag bit positions.
package zap_add64_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_ADC = 2'b01,
        OP_SUB = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/zap_add64_seq_if.sv
// Operand/result handshake bundle between MAC issue, the 64-bit add sequencer
// and writeback. slave is the sequencer's view, master the surrounding logic's.
interface zap_add64_seq_if;
    import zap_add64_pkg::*;

    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_a;
    logic [63:0] i_b;
    op_e         i_op;
    logic        i_cin;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_result;
    logic [3:0]  o_flags;
    logic        o_busy;

    modport slave (
        input  i_valid, i_a, i_b, i_op, i_cin, i_ready,
        output o_ready, o_valid, o_result, o_flags, o_busy
    );

    modport master (
        output i_valid, i_a, i_b, i_op, i_cin, i_ready,
        input  o_ready, o_valid, o_result, o_flags, o_busy
    );

endinterface

// File: rtl/zap_adder.sv
// 32-bit carry-in adder slice; bit 32 of o_sum is the carry out.
module zap_adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [32:0] o_sum
);

    assign o_sum = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};

endmodule

// File: rtl/zap_add64_seq.sv
// Multi-cycle 64-bit add/subtract: one 32-bit slice reused for the low word,
// then the high word with the low carry. Result and NZCV flags are held in DONE.
module zap_add64_seq
    import zap_add64_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic           i_clear,
    zap_add64_seq_if.slave bus
);

    logic [1:0]  state_q, state_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic        cin_q, cin_d;
    logic [31:0] lo_q, lo_d;
    logic        c32_q, c32_d;
    logic [63:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;
    logic        valid_q, valid_d;

    logic        ready;
    logic        accept;
    logic [63:0] b_prep;
    logic        cin0;
    logic [31:0] add_a, add_b;
    logic        add_ci;
    logic [32:0] sum;
    logic [63:0] r_full;

    assign ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.i_ready);
    assign accept = bus.i_valid && ready;

    // Subtraction is A + ~B + cin0, so b' and cin0 fully encode the op.
    always_comb begin
        b_prep = bus.i_b;
        cin0   = 1'b0;
        case (bus.i_op)
            OP_ADD: begin b_prep = bus.i_b;  cin0 = 1'b0;      end
            OP_ADC: begin b_prep = bus.i_b;  cin0 = bus.i_cin; end
            OP_SUB: begin b_prep = ~bus.i_b; cin0 = 1'b1;      end
            OP_SBC: begin b_prep = ~bus.i_b; cin0 = bus.i_cin; end
            default: ;
        endcase
    end

    always_comb begin
        add_a  = 32'd0;
        add_b  = 32'd0;
        add_ci = 1'b0;
        if (state_q == ST_LO) begin
            add_a  = a_q[31:0];
            add_b  = b_q[31:0];
            add_ci = cin_q;
        end else if (state_q == ST_HI) begin
            add_a  = a_q[63:32];
            add_b  = b_q[63:32];
            add_ci = c32_q;
        end
    end

    zap_adder u_adder (
        .i_a   (add_a),
        .i_b   (add_b),
        .i_cin (add_ci),
        .o_sum (sum)
    );

    assign r_full = {sum[31:0], lo_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        lo_d     = lo_q;
        c32_d    = c32_q;
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = valid_q;

        if (i_clear) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_d     = bus.i_a;
                        b_d     = b_prep;
                        cin_d   = cin0;
                        state_d = ST_LO;
                    end
                end
                ST_LO: begin
                    lo_d    = sum[31:0];
                    c32_d   = sum[32];
                    state_d = ST_HI;
                end
                ST_HI: begin
                    result_d         = r_full;
                    flags_d[FLAG_N]  = sum[31];
                    flags_d[FLAG_Z]  = (r_full == 64'd0);
                    flags_d[FLAG_C]  = sum[32];
                    flags_d[FLAG_V]  = (a_q[63] == b_q[63]) && (sum[31] != a_q[63]);
                    valid_d          = 1'b1;
                    state_d          = ST_DONE;
                end
                ST_DONE: begin
                    if (bus.i_ready) begin
                        valid_d = 1'b0;
                        if (bus.i_valid) begin
                            a_d     = bus.i_a;
                            b_d     = b_prep;
                            cin_d   = cin0;
                            state_d = ST_LO;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            a_q      <= 64'd0;
            b_q      <= 64'd0;
            cin_q    <= 1'b0;
            lo_q     <= 32'd0;
            c32_q    <= 1'b0;
            result_q <= 64'd0;
            flags_q  <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            lo_q     <= lo_d;
            c32_q    <= c32_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.o_ready  = ready;
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign bus.o_flags  = flags_q;
    assign bus.o_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_zap_add64_seq.sv
// Directed bench for zap_add64_seq: hand-computed results/flags, latency,
// backpressure with chained issue, flush and asynchronous reset.
module tb_zap_add64_seq;
    import zap_add64_pkg::*;

    logic clk;
    logic rst_n;
    logic clear;
    int   n_chk;
    int   n_bad;

    zap_add64_seq_if bus ();

    zap_add64_seq dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_clear   (clear),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_e op, input logic [63:0] a, input logic [63:0] b, input logic cin);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_cin   = cin;
    endtask

    // Issue from IDLE with i_ready=1; check latency, result, flags and 1-cycle pulse.
    task automatic run_op(input string tag, input op_e op, input logic [63:0] a,
                          input logic [63:0] b, input logic cin,
                          input logic [63:0] exp_r, input logic [3:0] exp_f);
        bus.i_ready = 1'b1;
        drive(op, a, b, cin);
        tick();
        bus.i_valid = 1'b0;
        chk({tag, ".v_e1"}, 64'(bus.o_valid), 64'd0);
        tick();
        chk({tag, ".v_e2pre"}, 64'(bus.o_valid), 64'd0);
        tick();
        chk({tag, ".v"}, 64'(bus.o_valid), 64'd1);
        chk({tag, ".res"}, bus.o_result, exp_r);
        chk({tag, ".flg"}, 64'(bus.o_flags), 64'(exp_f));
        tick();
        chk({tag, ".pulse"}, 64'(bus.o_valid), 64'd0);
        chk({tag, ".idle"}, 64'(bus.o_busy), 64'd0);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_a = 64'd0;
        bus.i_b = 64'd0;
        bus.i_op = OP_ADD;
        bus.i_cin = 1'b0;
        #22 rst_n = 1'b1;
        tick();

        chk("rst.ready", 64'(bus.o_ready), 64'd1);
        chk("rst.valid", 64'(bus.o_valid), 64'd0);
        chk("rst.res",   bus.o_result, 64'd0);
        chk("rst.flg",   64'(bus.o_flags), 64'd0);
        chk("rst.busy",  64'(bus.o_busy), 64'd0);

        run_op("add_c32", OP_ADD, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 4'b0000);
        run_op("sub_eq",  OP_SUB, 64'd5, 64'd5, 1'b0, 64'd0, 4'b0110);
        run_op("sub_neg", OP_SUB, 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
        run_op("add_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001);
        run_op("adc_wrap", OP_ADC, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 4'b0110);
        run_op("sbc",     OP_SBC, 64'd10, 64'd3, 1'b0, 64'd6, 4'b0010);

        // Backpressure: result held in DONE, then chained issue on release.
        bus.i_ready = 1'b0;
        drive(OP_ADD, 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 1'b0);
        tick();
        bus.i_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", 64'(bus.o_valid), 64'd1);
            chk("bp.res",   bus.o_result, 64'h0000_0004_0000_0006);
            chk("bp.flg",   64'(bus.o_flags), 64'd0);
            chk("bp.ready", 64'(bus.o_ready), 64'd0);
            tick();
        end
        bus.i_ready = 1'b1;
        drive(OP_SUB, 64'd100, 64'd1, 1'b0);
        #1;
        chk("chain.ready", 64'(bus.o_ready), 64'd1);
        tick();
        bus.i_valid = 1'b0;
        chk("chain.v_e1", 64'(bus.o_valid), 64'd0);
        chk("chain.busy", 64'(bus.o_busy), 64'd1);
        tick();
        chk("chain.v_e2pre", 64'(bus.o_valid), 64'd0);
        tick();
        chk("chain.v",   64'(bus.o_valid), 64'd1);
        chk("chain.res", bus.o_result, 64'd99);
        chk("chain.flg", 64'(bus.o_flags), 64'b0010);
        tick();
        chk("chain.pulse", 64'(bus.o_valid), 64'd0);

        // Flush while in HI: nothing emitted, previous result kept.
        drive(OP_ADD, 64'd7, 64'd8, 1'b0);
        tick();
        bus.i_valid = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr.valid", 64'(bus.o_valid), 64'd0);
        chk("clr.busy",  64'(bus.o_busy), 64'd0);
        chk("clr.ready", 64'(bus.o_ready), 64'd1);
        chk("clr.res",   bus.o_result, 64'd99);
        tick();
        chk("clr.valid2", 64'(bus.o_valid), 64'd0);

        // Async reset mid-LO, between edges.
        drive(OP_ADD, 64'd40, 64'd2, 1'b0);
        tick();
        bus.i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", 64'(bus.o_valid), 64'd0);
        chk("arst.res",   bus.o_result, 64'd0);
        chk("arst.flg",   64'(bus.o_flags), 64'd0);
        chk("arst.busy",  64'(bus.o_busy), 64'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        run_op("post_rst", OP_ADD, 64'd2, 64'd3, 1'b0, 64'd5, 4'b0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
